// File: rtl/cmos_pkg.sv
// Shared types for the synthetic CMOS source: frame FSM states and test pattern codes.
package cmos_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_VS   = 3'd1,
      ST_VBP  = 3'd2,
      ST_ACT  = 3'd3,
      ST_VFP  = 3'd4
   } state_t;

   localparam logic [1:0] PAT_HRAMP = 2'd0;
   localparam logic [1:0] PAT_VRAMP = 2'd1;
   localparam logic [1:0] PAT_FLAT  = 2'd2;
   localparam logic [1:0] PAT_DOT   = 2'd3;

endpackage

// File: rtl/cmos_line_timer.sv
// Pixel counter across one line of L cycles; held at 0 while not running.
module cmos_line_timer #(
   parameter int  L  = 800,
   localparam int XW = (L > 1) ? $clog2(L) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          run,
   output logic [XW-1:0] x,
   output logic          line_end
);

   assign line_end = run && (x == XW'(L - 1));

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n)
         x <= '0;
      else if (!run || line_end)
         x <= '0;
      else
         x <= x + 1'b1;
   end

endmodule

// File: rtl/cmos_pattern_gen.sv
// Synthetic camera source: vsync/href/8-bit pixel frames with selectable test patterns.
module cmos_pattern_gen
   import cmos_pkg::*;
#(
   parameter int H_ACTIVE  = 640,
   parameter int H_BLANK   = 160,
   parameter int V_ACTIVE  = 480,
   parameter int VS_LINES  = 2,
   parameter int VBP_LINES = 23,
   parameter int VFP_LINES = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [1:0] pattern_sel,
   input  logic [7:0] peak_value,
   output logic       cmos_frame_vsync,
   output logic       cmos_frame_href,
   output logic [7:0] cmos_frame_data,
   output logic       frame_done
);

   localparam int L    = H_ACTIVE + H_BLANK;
   localparam int XW   = (L > 1) ? $clog2(L) : 1;
   localparam int YM1  = (VS_LINES > VBP_LINES) ? VS_LINES : VBP_LINES;
   localparam int YM2  = (V_ACTIVE > VFP_LINES) ? V_ACTIVE : VFP_LINES;
   localparam int YMAX = (YM1 > YM2) ? YM1 : YM2;
   localparam int YW   = (YMAX > 1) ? $clog2(YMAX) : 1;

   state_t          state, state_nx;
   logic [YW-1:0]   y, y_nx;
   logic [XW-1:0]   x;
   logic            line_end, last_line, frame_last, start;
   logic [1:0]      pat_q;
   logic [7:0]      peak_q;
   logic            href_nx;
   logic [7:0]      pix;

   cmos_line_timer #(.L(L)) u_line_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (state != ST_IDLE),
      .x        (x),
      .line_end (line_end)
   );

   always_comb begin
      last_line = 1'b0;
      case (state)
         ST_VS:   last_line = (y == YW'(VS_LINES - 1));
         ST_VBP:  last_line = (y == YW'(VBP_LINES - 1));
         ST_ACT:  last_line = (y == YW'(V_ACTIVE - 1));
         ST_VFP:  last_line = (y == YW'(VFP_LINES - 1));
         default: last_line = 1'b0;
      endcase
   end

   always_comb begin
      state_nx   = state;
      y_nx       = y;
      start      = 1'b0;
      frame_last = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable) begin
               state_nx = ST_VS;
               start    = 1'b1;
            end
         end
         ST_VS, ST_VBP, ST_ACT, ST_VFP: begin
            if (line_end) begin
               if (!last_line) begin
                  y_nx = y + 1'b1;
               end else begin
                  y_nx = '0;
                  case (state)
                     ST_VS:   state_nx = (VBP_LINES > 0) ? ST_VBP : ST_ACT;
                     ST_VBP:  state_nx = ST_ACT;
                     ST_ACT:  if (VFP_LINES > 0) state_nx = ST_VFP;
                              else frame_last = 1'b1;
                     default: frame_last = 1'b1;
                  endcase
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
      // Back-to-back frames: the next frame starts on the edge that ends this one.
      if (frame_last) begin
         state_nx = enable ? ST_VS : ST_IDLE;
         start    = enable;
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state  <= ST_IDLE;
         y      <= '0;
         pat_q  <= PAT_HRAMP;
         peak_q <= '0;
      end else begin
         state <= state_nx;
         y     <= y_nx;
         if (start) begin
            pat_q  <= pattern_sel;
            peak_q <= peak_value;
         end
      end
   end

   assign href_nx = (state == ST_ACT) && (x < XW'(H_ACTIVE));

   always_comb begin
      pix = '0;
      case (pat_q)
         PAT_HRAMP: pix = 8'(x);
         PAT_VRAMP: pix = 8'(y);
         PAT_FLAT:  pix = peak_q;
         default:   pix = ((x == XW'(H_ACTIVE / 2)) && (y == YW'(V_ACTIVE / 2))) ? peak_q : 8'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         cmos_frame_vsync <= 1'b0;
         cmos_frame_href  <= 1'b0;
         cmos_frame_data  <= '0;
         frame_done       <= 1'b0;
      end else begin
         cmos_frame_vsync <= (state == ST_VS);
         cmos_frame_href  <= href_nx;
         cmos_frame_data  <= href_nx ? pix : 8'd0;
         frame_done       <= frame_last;
      end
   end

endmodule

// File: doc/cmos_pattern_gen.md
# cmos_pattern_gen

Synthetic CMOS camera source that drives the same vsync/href/8-bit pixel interface the downstream luminance-statistics blocks (peak tracker) consume. Generates frames with programmable geometry and blanking plus a selectable test pattern, including a single-pixel peak marker, so capture-side blocks can be exercised without a sensor. It sits in place of the sensor capture front-end and feeds the pixel pipeline directly.

## Interface
- H_ACTIVE, 640, active pixels per line (href high cycles)
- H_BLANK, 160, cycles per line with href low (≥1)
- V_ACTIVE, 480, active lines per frame
- VS_LINES, 2, lines with vsync high at frame start (≥1)
- VBP_LINES, 23, back-porch lines after vsync (≥0)
- VFP_LINES, 10, front-porch lines after active region (≥0)
- clk  input  1  pixel clock
- rst_n  input  1  reset; asynchronous, active-high; clock clk
- enable  input  1  level; start/continue frame generation
- pattern_sel  input  2  0 h-ramp, 1 v-ramp, 2 flat, 3 peak-dot
- peak_value  input  8  flat level / dot level
- cmos_frame_vsync  output  1  frame sync, high during VS lines
- cmos_frame_href  output  1  line valid, high during active pixels
- cmos_frame_data  output  8  pixel value, 0 whenever href low
- frame_done  output  1  one-cycle pulse on last cycle of each frame

## Operation
- FSM states: IDLE, VS, VBP, ACT, VFP. Every non-IDLE state runs in whole lines of L = H_ACTIVE+H_BLANK cycles; pixel counter x (0..L-1), line counter y within state.
- IDLE: all outputs 0. enable=1 → VS, latching pattern_sel and peak_value into frame registers (held constant for the whole frame).
- VS: vsync=1 for VS_LINES lines → VBP (or ACT if VBP_LINES=0).
- VBP: VBP_LINES lines, all low → ACT.
- ACT: V_ACTIVE lines; in each, href=1 for x<H_ACTIVE, 0 for remaining H_BLANK cycles → VFP (or frame end if VFP_LINES=0).
- VFP: VFP_LINES lines low. Frame end (last cycle of last line): frame_done=1; enable=1 → VS with fresh latch (back-to-back frames, no gap), else IDLE.
- Pattern, active pixels only (x = active column, y = active line): 0 data=x[7:0]; 1 data=y[7:0]; 2 data=peak_value; 3 data=peak_value at (H_ACTIVE/2, V_ACTIVE/2), else 0.
- enable dropping mid-frame: current frame completes, then IDLE. Changes to pattern_sel/peak_value mid-frame ignored until next frame start.
- Reset (any time, including mid-line): state IDLE, counters 0, all outputs 0 immediately.

## Timing
- All outputs registered; vsync, href, data, frame_done change on the same clk edge and stay mutually aligned.
- enable sampled high in IDLE at edge N → vsync=1 after edge N+1 (one cycle latency).
- Frame period = (VS_LINES+VBP_LINES+V_ACTIVE+VFP_LINES)·L cycles exactly; frame_done asserted in the final cycle; vsync of next frame follows with no idle cycle.
- href rises at line start (x=0) of each ACT line; exactly H_ACTIVE high cycles per line, V_ACTIVE href pulses per frame.
- Counter widths: $clog2 of the respective maximum; x/y wrap at terminal count, never free-run.

## Structure
- Shared package cmos_pkg: state enum (IDLE, VS, VBP, ACT, VFP), pattern code constants (PAT_HRAMP=0, PAT_VRAMP=1, PAT_FLAT=2, PAT_DOT=3).
- One sub-module: cmos_line_timer — pixel counter x with line-end strobe, parameterised on L; FSM and line counting stay in the top.

## Test plan
- Params H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, VS=1, VBP=1, VFP=1, enable=1 one frame → vsync high 12 cycles, 4 href pulses of 8 cycles, frame_done at cycle 84, next vsync at cycle 85.
- Same params, pattern 0 → every active line data 0,1,…,7; pattern 1 → line k data all k.
- Pattern 3, peak_value=200 → exactly one pixel =200 at active (4,2), all others 0; a downstream peak tracker reads 200.
- peak_value changed 50→90 and pattern 2→0 mid-frame → current frame stays flat 50; next frame h-ramp.
- enable dropped during ACT line 1 → frame completes incl. frame_done, then IDLE, outputs 0, no new vsync.
- rst_n pulsed during an href-high cycle → vsync/href/data/frame_done 0 immediately; after release with enable=1, vsync rises one cycle later and full frame follows.
